// File: rtl/miriscv_gpr_pkg.sv
// General-purpose register file types shared by decode, writeback and the GPR array.
package miriscv_gpr_pkg;

  localparam int unsigned GPR_ADDR_WIDTH = 5;
  localparam int unsigned GPR_NUM_REGS   = 2 ** GPR_ADDR_WIDTH;

  typedef logic [GPR_ADDR_WIDTH-1:0] gpr_addr_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_EX   = 2'd1,
    WB_SRC_LSU  = 2'd2
  } wb_src_e;

endpackage : miriscv_gpr_pkg

// File: rtl/miriscv_pkg.sv
// Core-wide parameters for miriscv.
package miriscv_pkg;

  localparam int unsigned XLEN = 32;

endpackage : miriscv_pkg

// File: rtl/miriscv_gpr_scoreboard.sv
// Per-register busy bits for loads still in flight; x0 can never be busy.
module miriscv_gpr_scoreboard
  import miriscv_gpr_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      set_i,
  input  gpr_addr_t set_addr_i,
  input  logic      clr_i,
  input  gpr_addr_t clr_addr_i,
  input  gpr_addr_t r1_addr_i,
  input  gpr_addr_t r2_addr_i,
  input  gpr_addr_t ex_addr_i,
  input  gpr_addr_t issue_addr_i,
  output logic      r1_busy_o,
  output logic      r2_busy_o,
  output logic      ex_busy_o,
  output logic      issue_busy_o,
  output logic      idle_o
);

  logic [GPR_NUM_REGS-1:0] busy_q;
  logic [GPR_NUM_REGS-1:0] busy_d;

  // Set takes precedence so a new load to a just-written register stays tracked.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int unsigned i = 1; i < GPR_NUM_REGS; i++) begin
      if (set_i && (set_addr_i == gpr_addr_t'(i))) begin
        busy_d[i] = 1'b1;
      end else if (clr_i && (clr_addr_i == gpr_addr_t'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign r1_busy_o    = busy_q[r1_addr_i];
  assign r2_busy_o    = busy_q[r2_addr_i];
  assign ex_busy_o    = busy_q[ex_addr_i];
  assign issue_busy_o = busy_q[issue_addr_i];
  assign idle_o       = ~(|busy_q);

endmodule : miriscv_gpr_scoreboard

// File: rtl/miriscv_gpr_wb_ctrl.sv
// GPR write-port arbiter between EX and LSU writeback, LSU-first with bounded EX starvation,
// plus the outstanding-load scoreboard used by decode interlocks.
module miriscv_gpr_wb_ctrl
  import miriscv_pkg::*;
  import miriscv_gpr_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      lsu_issue_i,
  input  logic [GPR_ADDR_WIDTH-1:0] lsu_issue_rd_i,
  output logic                      lsu_issue_ready_o,
  input  logic [GPR_ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [GPR_ADDR_WIDTH-1:0] r2_addr_i,
  output logic                      r1_busy_o,
  output logic                      r2_busy_o,
  input  logic                      ex_wb_valid_i,
  output logic                      ex_wb_ready_o,
  input  logic [GPR_ADDR_WIDTH-1:0] ex_wb_addr_i,
  input  logic [XLEN-1:0]           ex_wb_data_i,
  input  logic                      lsu_wb_valid_i,
  output logic                      lsu_wb_ready_o,
  input  logic [GPR_ADDR_WIDTH-1:0] lsu_wb_addr_i,
  input  logic [XLEN-1:0]           lsu_wb_data_i,
  output logic                      gpr_wr_en_o,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_wr_addr_o,
  output logic [XLEN-1:0]           gpr_wr_data_o,
  output logic                      idle_o
);

  localparam logic [3:0] MaxStarve = 4'(MAX_STARVE);

  logic [3:0] starve_q;
  logic [3:0] starve_d;
  wb_src_e    grant;
  logic       ex_busy;
  logic       issue_busy;
  logic       r1_busy;
  logic       r2_busy;
  logic       sb_idle;
  logic       issue_ready;
  logic       ex_elig;
  logic       ex_xfer;
  logic       lsu_xfer;
  logic       sb_set;

  assign issue_ready = rst_n_i & ~issue_busy;
  assign ex_elig     = ex_wb_valid_i & ~ex_busy;
  assign sb_set      = lsu_issue_i & issue_ready & (lsu_issue_rd_i != '0);

  miriscv_gpr_scoreboard u_scoreboard (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .set_i        (sb_set),
    .set_addr_i   (lsu_issue_rd_i),
    .clr_i        (lsu_xfer),
    .clr_addr_i   (lsu_wb_addr_i),
    .r1_addr_i    (r1_addr_i),
    .r2_addr_i    (r2_addr_i),
    .ex_addr_i    (ex_wb_addr_i),
    .issue_addr_i (lsu_issue_rd_i),
    .r1_busy_o    (r1_busy),
    .r2_busy_o    (r2_busy),
    .ex_busy_o    (ex_busy),
    .issue_busy_o (issue_busy),
    .idle_o       (sb_idle)
  );

  // EX only overtakes a valid LSU once it has been denied MAX_STARVE times.
  always_comb begin
    grant = WB_SRC_NONE;
    if (!rst_n_i) begin
      grant = WB_SRC_NONE;
    end else if (ex_elig && ((starve_q == MaxStarve) || !lsu_wb_valid_i)) begin
      grant = WB_SRC_EX;
    end else if (lsu_wb_valid_i) begin
      grant = WB_SRC_LSU;
    end else begin
      grant = WB_SRC_NONE;
    end
  end

  assign ex_xfer        = (grant == WB_SRC_EX);
  assign lsu_xfer       = (grant == WB_SRC_LSU);
  assign ex_wb_ready_o  = ex_xfer;
  assign lsu_wb_ready_o = lsu_xfer;

  always_comb begin
    gpr_wr_addr_o = '0;
    gpr_wr_data_o = '0;
    case (grant)
      WB_SRC_EX: begin
        gpr_wr_addr_o = ex_wb_addr_i;
        gpr_wr_data_o = ex_wb_data_i;
      end
      WB_SRC_LSU: begin
        gpr_wr_addr_o = lsu_wb_addr_i;
        gpr_wr_data_o = lsu_wb_data_i;
      end
      default: begin
        gpr_wr_addr_o = '0;
        gpr_wr_data_o = '0;
      end
    endcase
  end

  assign gpr_wr_en_o = (ex_xfer | lsu_xfer) & (gpr_wr_addr_o != '0);

  // A held (busy-target) EX request is not being starved, so the count only moves when eligible.
  always_comb begin
    starve_d = starve_q;
    if (ex_xfer) begin
      starve_d = 4'd0;
    end else if (ex_elig && (starve_q < MaxStarve)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign lsu_issue_ready_o = issue_ready;
  assign r1_busy_o         = rst_n_i & r1_busy;
  assign r2_busy_o         = rst_n_i & r2_busy;
  assign idle_o            = ~rst_n_i | sb_idle;

endmodule : miriscv_gpr_wb_ctrl

// File: tb/tb_miriscv_gpr_wb_ctrl.sv
// Directed bench for miriscv_gpr_wb_ctrl: a vector table for single-cycle behaviour plus
// sequences for starvation, WAW holding and reset.
module tb_miriscv_gpr_wb_ctrl;

  typedef struct {
    logic        rst_n;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ex_v;
    logic [4:0]  ex_a;
    logic [31:0] ex_d;
    logic        lsu_v;
    logic [4:0]  lsu_a;
    logic [31:0] lsu_d;
    logic        e_ir;
    logic        e_r1b;
    logic        e_r2b;
    logic        e_exr;
    logic        e_lr;
    logic        e_en;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    logic        e_idle;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        lsu_issue_i = 1'b0;
  logic [4:0]  lsu_issue_rd_i = 5'd0;
  logic        lsu_issue_ready_o;
  logic [4:0]  r1_addr_i = 5'd0;
  logic [4:0]  r2_addr_i = 5'd0;
  logic        r1_busy_o;
  logic        r2_busy_o;
  logic        ex_wb_valid_i = 1'b0;
  logic        ex_wb_ready_o;
  logic [4:0]  ex_wb_addr_i = 5'd0;
  logic [31:0] ex_wb_data_i = 32'd0;
  logic        lsu_wb_valid_i = 1'b0;
  logic        lsu_wb_ready_o;
  logic [4:0]  lsu_wb_addr_i = 5'd0;
  logic [31:0] lsu_wb_data_i = 32'd0;
  logic        gpr_wr_en_o;
  logic [4:0]  gpr_wr_addr_o;
  logic [31:0] gpr_wr_data_o;
  logic        idle_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  miriscv_gpr_wb_ctrl #(.MAX_STARVE(4)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n_i),
    .lsu_issue_i       (lsu_issue_i),
    .lsu_issue_rd_i    (lsu_issue_rd_i),
    .lsu_issue_ready_o (lsu_issue_ready_o),
    .r1_addr_i         (r1_addr_i),
    .r2_addr_i         (r2_addr_i),
    .r1_busy_o         (r1_busy_o),
    .r2_busy_o         (r2_busy_o),
    .ex_wb_valid_i     (ex_wb_valid_i),
    .ex_wb_ready_o     (ex_wb_ready_o),
    .ex_wb_addr_i      (ex_wb_addr_i),
    .ex_wb_data_i      (ex_wb_data_i),
    .lsu_wb_valid_i    (lsu_wb_valid_i),
    .lsu_wb_ready_o    (lsu_wb_ready_o),
    .lsu_wb_addr_i     (lsu_wb_addr_i),
    .lsu_wb_data_i     (lsu_wb_data_i),
    .gpr_wr_en_o       (gpr_wr_en_o),
    .gpr_wr_addr_o     (gpr_wr_addr_o),
    .gpr_wr_data_o     (gpr_wr_data_o),
    .idle_o            (idle_o)
  );

  function automatic vec_t mkv(int issue, int ird, int r1, int r2,
                               int exv, int exa, logic [31:0] exd,
                               int lv, int la, logic [31:0] ld,
                               int e_ir, int e_r1b, int e_r2b, int e_exr, int e_lr,
                               int e_en, int e_a, logic [31:0] e_d, int e_idle);
    vec_t v;
    v.rst_n    = 1'b1;
    v.issue    = (issue != 0);
    v.issue_rd = 5'(ird);
    v.r1       = 5'(r1);
    v.r2       = 5'(r2);
    v.ex_v     = (exv != 0);
    v.ex_a     = 5'(exa);
    v.ex_d     = exd;
    v.lsu_v    = (lv != 0);
    v.lsu_a    = 5'(la);
    v.lsu_d    = ld;
    v.e_ir     = (e_ir != 0);
    v.e_r1b    = (e_r1b != 0);
    v.e_r2b    = (e_r2b != 0);
    v.e_exr    = (e_exr != 0);
    v.e_lr     = (e_lr != 0);
    v.e_en     = (e_en != 0);
    v.e_a      = 5'(e_a);
    v.e_d      = e_d;
    v.e_idle   = (e_idle != 0);
    return v;
  endfunction

  // Drive just after the rising edge, compare on the falling edge of the same cycle.
  task automatic apply(input vec_t v, input string name);
    logic [43:0] got;
    logic [43:0] exp;
    @(posedge clk);
    #1;
    rst_n_i        = v.rst_n;
    lsu_issue_i    = v.issue;
    lsu_issue_rd_i = v.issue_rd;
    r1_addr_i      = v.r1;
    r2_addr_i      = v.r2;
    ex_wb_valid_i  = v.ex_v;
    ex_wb_addr_i   = v.ex_a;
    ex_wb_data_i   = v.ex_d;
    lsu_wb_valid_i = v.lsu_v;
    lsu_wb_addr_i  = v.lsu_a;
    lsu_wb_data_i  = v.lsu_d;
    @(negedge clk);
    got = {lsu_issue_ready_o, r1_busy_o, r2_busy_o, ex_wb_ready_o, lsu_wb_ready_o,
           gpr_wr_en_o, idle_o, gpr_wr_addr_o, gpr_wr_data_o};
    exp = {v.e_ir, v.e_r1b, v.e_r2b, v.e_exr, v.e_lr, v.e_en, v.e_idle, v.e_a, v.e_d};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {ir,r1b,r2b,exr,lsur,en,idle,addr,data}=%h expected %h",
               name, got, exp);
    end
  endtask

  vec_t tbl [10];
  vec_t v;

  initial begin
    tbl[0] = mkv(0,0,0,0, 1,5,32'h1234_5678, 0,0,32'h0,          1,0,0, 1,0,1,5,32'h1234_5678, 1);
    tbl[1] = mkv(0,0,0,0, 0,0,32'h0,         1,6,32'hAAAA_0001,  1,0,0, 0,1,1,6,32'hAAAA_0001, 1);
    tbl[2] = mkv(0,0,0,0, 1,3,32'h0000_3333, 1,4,32'h0000_4444,  1,0,0, 0,1,1,4,32'h0000_4444, 1);
    tbl[3] = mkv(0,0,0,0, 1,0,32'hFFFF_FFFF, 0,0,32'h0,          1,0,0, 1,0,0,0,32'hFFFF_FFFF, 1);
    tbl[4] = mkv(0,0,0,0, 0,0,32'h0,         1,0,32'h0000_0001,  1,0,0, 0,1,0,0,32'h0000_0001, 1);
    tbl[5] = mkv(0,0,0,0, 0,0,32'h0,         0,0,32'h0,          1,0,0, 0,0,0,0,32'h0,         1);
    tbl[6] = mkv(1,7,7,0, 0,0,32'h0,         0,0,32'h0,          1,0,0, 0,0,0,0,32'h0,         1);
    tbl[7] = mkv(1,7,7,5, 0,0,32'h0,         0,0,32'h0,          0,1,0, 0,0,0,0,32'h0,         0);
    tbl[8] = mkv(1,7,7,0, 0,0,32'h0,         1,7,32'h0000_0077,  0,1,0, 0,1,1,7,32'h0000_0077, 0);
    tbl[9] = mkv(0,7,7,0, 0,0,32'h0,         0,0,32'h0,          1,0,0, 0,0,0,0,32'h0,         1);

    v = mkv(0,0,0,0, 0,0,32'h0, 0,0,32'h0, 0,0,0, 0,0,0,0,32'h0, 1);
    v.rst_n = 1'b0;
    apply(v, "reset_state");

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // Continuous LSU traffic: EX wins every fifth cycle, proving the count restarts after a win.
    for (int c = 1; c <= 10; c++) begin
      int exw;
      exw = ((c % 5) == 0) ? 1 : 0;
      v = mkv(0,0,0,0, 1,3,32'h0300_0000 + 32'(c), 1,10,32'h0A00_0000 + 32'(c),
              1,0,0, exw, 1 - exw, 1, (exw != 0) ? 3 : 10,
              (exw != 0) ? (32'h0300_0000 + 32'(c)) : (32'h0A00_0000 + 32'(c)), 1);
      apply(v, $sformatf("starve_c%0d", c));
    end

    // EX to a register with an outstanding load is held and must not accumulate starvation.
    apply(mkv(1,9,0,0, 0,0,32'h0, 0,0,32'h0, 1,0,0, 0,0,0,0,32'h0, 1), "waw_issue9");
    for (int k = 1; k <= 3; k++) begin
      apply(mkv(0,0,9,0, 1,9,32'h9999_00AA, 1,11,32'hBBBB_0000 + 32'(k),
                1,1,0, 0,1,1,11,32'hBBBB_0000 + 32'(k), 0), $sformatf("waw_hold%0d", k));
    end
    apply(mkv(0,0,9,0, 1,9,32'h9999_00AA, 1,9,32'h9090_9090,
              1,1,0, 0,1,1,9,32'h9090_9090, 0), "waw_lsu9");
    apply(mkv(0,0,9,0, 1,9,32'h9999_00AA, 1,11,32'hBBBB_0005,
              1,0,0, 0,1,1,11,32'hBBBB_0005, 1), "waw_no_starve");
    apply(mkv(0,0,9,0, 1,9,32'h9999_0006, 0,0,32'h0,
              1,0,0, 1,0,1,9,32'h9999_0006, 1), "waw_ex9");

    // Reset with three loads outstanding.
    for (int k = 1; k <= 3; k++) begin
      apply(mkv(1,k,k,0, 0,0,32'h0, 0,0,32'h0, 1,0,0, 0,0,0,0,32'h0, (k == 1) ? 1 : 0),
            $sformatf("rst_issue%0d", k));
    end
    apply(mkv(0,0,1,3, 0,0,32'h0, 0,0,32'h0, 1,1,1, 0,0,0,0,32'h0, 0), "rst_busy_before");
    v = mkv(1,1,1,2, 1,4,32'h4444_4444, 1,5,32'h5555_5555, 0,0,0, 0,0,0,0,32'h0, 1);
    v.rst_n = 1'b0;
    apply(v, "rst_forced");
    for (int k = 1; k <= 3; k++) begin
      apply(mkv(0,k,k,0, 0,0,32'h0, 0,0,32'h0, 1,0,0, 0,0,0,0,32'h0, 1),
            $sformatf("rst_after%0d", k));
    end
    apply(mkv(0,0,0,0, 0,0,32'h0, 1,2,32'h2222_2222, 1,0,0, 0,1,1,2,32'h2222_2222, 1),
          "rst_late_lsu");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_miriscv_gpr_wb_ctrl
